// File: rtl/instr_encoder_if.sv
// Instruction-field stream from the boot/test front end into the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (
        output in_valid, in_last, op_sel, rs, rt, rd, shamt, funct, imm, target,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, op_sel, rs, rt, rd, shamt, funct, imm, target,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: encodes MIPS instruction fields, buffers them in a 4-deep FIFO
// and writes them to consecutive instruction-memory words.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    instr_encoder_if.slave      in_if,
    output logic                im_we,
    output logic [ADDR_W-1:0]   im_addr,
    output logic [31:0]         im_wdata,
    output logic                busy,
    output logic                done,
    output logic                bad_op,
    output logic                overflow,
    output logic [ADDR_W:0]     words_written
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;

    localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    state_t            state;
    logic [31:0]       fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc;
    logic              push;
    logic              pop;

    // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign in_if.in_ready = (state == LOAD) && (count < 3'd4);
    assign push = in_if.in_valid && in_if.in_ready;
    assign pop  = (count != 3'd0);

    always_comb begin
        enc = '0;
        case (in_if.op_sel)
            3'd0: enc = {6'b000000, in_if.rs, in_if.rt, in_if.rd, in_if.shamt, in_if.funct};
            3'd1: enc = {6'b100011, in_if.rs, in_if.rt, in_if.imm};
            3'd2: enc = {6'b101011, in_if.rs, in_if.rt, in_if.imm};
            3'd3: enc = {6'b000100, in_if.rs, in_if.rt, in_if.imm};
            3'd4: enc = {6'b001000, in_if.rs, in_if.rt, in_if.imm};
            3'd5: enc = {6'b000010, in_if.target};
            default: enc = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            addr          <= '0;
            im_we         <= 1'b0;
            im_addr       <= '0;
            im_wdata      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bad_op        <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= enc;
                wr_ptr           <= wr_ptr + 2'd1;
                if (in_if.op_sel >= 3'd6) bad_op <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};

            // Past the top address words are still popped but silently dropped.
            im_we <= 1'b0;
            if (pop && !overflow) begin
                im_we         <= 1'b1;
                im_addr       <= addr;
                im_wdata      <= fifo_mem[rd_ptr];
                words_written <= words_written + (ADDR_W+1)'(1);
                if (addr == TOP_ADDR) overflow <= 1'b1;
                else                  addr     <= addr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= LOAD;
                        busy          <= 1'b1;
                        addr          <= BASE_ADDR;
                        words_written <= '0;
                        bad_op        <= 1'b0;
                        overflow      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (push && in_if.in_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (count == 3'd0) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized/directed bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    bit   sel = 1'b0;
    always #5 clk = ~clk;

    logic        valid = 1'b0, last = 1'b0;
    logic [2:0]  op = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, sh = '0;
    logic [5:0]  fn = '0;
    logic [15:0] imm = '0;
    logic [25:0] tgt = '0;

    instr_encoder_if ifa();
    instr_encoder_if ifb();
    assign ifa.in_valid = valid; assign ifb.in_valid = valid;
    assign ifa.in_last = last;   assign ifb.in_last = last;
    assign ifa.op_sel = op;      assign ifb.op_sel = op;
    assign ifa.rs = rs;          assign ifb.rs = rs;
    assign ifa.rt = rt;          assign ifb.rt = rt;
    assign ifa.rd = rd;          assign ifb.rd = rd;
    assign ifa.shamt = sh;       assign ifb.shamt = sh;
    assign ifa.funct = fn;       assign ifb.funct = fn;
    assign ifa.imm = imm;        assign ifb.imm = imm;
    assign ifa.target = tgt;     assign ifb.target = tgt;

    logic we_a, busy_a, done_a, bad_a, ovf_a, we_b, busy_b, done_b, bad_b, ovf_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] wd_a, wd_b;
    logic [8:0]  ww_a, ww_b;

    instr_encoder #(.ADDR_W(8), .BASE(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_if(ifa),
        .im_we(we_a), .im_addr(addr_a), .im_wdata(wd_a), .busy(busy_a), .done(done_a),
        .bad_op(bad_a), .overflow(ovf_a), .words_written(ww_a)
    );
    instr_encoder #(.ADDR_W(8), .BASE(254)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_if(ifb),
        .im_we(we_b), .im_addr(addr_b), .im_wdata(wd_b), .busy(busy_b), .done(done_b),
        .bad_op(bad_b), .overflow(ovf_b), .words_written(ww_b)
    );

    wire       cur_ready = sel ? ifb.in_ready : ifa.in_ready;
    wire       cur_we    = sel ? we_b : we_a;
    wire       cur_done  = sel ? done_b : done_a;
    wire       cur_busy  = sel ? busy_b : busy_a;
    wire       cur_bad   = sel ? bad_b : bad_a;
    wire       cur_ovf   = sel ? ovf_b : ovf_a;
    wire [8:0] cur_ww    = sel ? ww_b : ww_a;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected (address, word) pairs per DUT, in write order.
    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t qa[$];
    wr_t qb[$];
    int  m_base = 0;
    int  m_n = 0;
    bit  m_bad = 1'b0;

    localparam longint P26 = 64'd67108864;
    localparam longint P21 = 64'd2097152;
    localparam longint P16 = 64'd65536;
    localparam longint P11 = 64'd2048;

    function automatic logic [31:0] ref_enc(input int o);
        longint w;
        case (o)
            0: w = rs * P21 + rt * P16 + rd * P11 + sh * 64 + fn;
            1: w = 35 * P26 + rs * P21 + rt * P16 + imm;
            2: w = 43 * P26 + rs * P21 + rt * P16 + imm;
            3: w = 4 * P26 + rs * P21 + rt * P16 + imm;
            4: w = 8 * P26 + rs * P21 + rt * P16 + imm;
            5: w = 2 * P26 + tgt;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic push_model(input int o, input logic [31:0] expw);
        wr_t e;
        if (m_base + m_n <= 255) begin
            e.a = 8'(m_base + m_n);
            e.d = expw;
            if (sel) qb.push_back(e); else qa.push_back(e);
        end
        m_n++;
        if (o >= 6) m_bad = 1'b1;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (we_a === 1'b1) begin
            if (qa.size() == 0) chk("spurious_we_a", we_a, 1'b0);
            else begin
                e = qa.pop_front();
                chk("addr_a", addr_a, e.a);
                chk("data_a", wd_a, e.d);
            end
        end
        if (we_b === 1'b1) begin
            if (qb.size() == 0) chk("spurious_we_b", we_b, 1'b0);
            else begin
                e = qb.pop_front();
                chk("addr_b", addr_b, e.a);
                chk("data_b", wd_b, e.d);
            end
        end
    end

    task automatic fields(input int r_s, input int r_t, input int r_d, input int s_h,
                          input int f_n, input int i_m, input int t_g);
        rs = 5'(r_s); rt = 5'(r_t); rd = 5'(r_d); sh = 5'(s_h);
        fn = 6'(f_n); imm = 16'(i_m); tgt = 26'(t_g);
    endtask

    task automatic send(input int o, input logic [31:0] expw, input bit lst, output int waits);
        op = 3'(o); last = lst; valid = 1'b1; waits = 0;
        while (!cur_ready && waits < 30) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!cur_ready) chk("ready_timeout", cur_ready, 1'b1);
        else push_model(o, expw);
        @(posedge clk); #1;
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic rand_beat(input bit lst, input int max_op, output int waits);
        int o;
        fields($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        o = $urandom_range(0, max_op);
        send(o, ref_enc(o), lst, waits);
    endtask

    task automatic start_sess(input bit s);
        sel = s;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        m_base = s ? 254 : 0; m_n = 0; m_bad = 1'b0;
        chk("ready_after_start", cur_ready, 1'b1);
        chk("busy_after_start", cur_busy, 1'b1);
    endtask

    task automatic wait_done(input bit check_lat);
        int last_we = -100;
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cur_we) last_we = i;
            if (cur_done) break;
        end
        chk("done_seen", cur_done, 1'b1);
        if (check_lat) chk("done_latency", i, last_we + 1);
        @(negedge clk);
        chk("done_one_pulse", cur_done, 1'b0);
        chk("busy_after_done", cur_busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic end_checks();
        int exp_ww;
        exp_ww = (m_base + m_n > 256) ? 256 - m_base : m_n;
        chk("words_written", cur_ww, exp_ww);
        chk("overflow", cur_ovf, (m_base + m_n >= 256));
        chk("bad_op", cur_bad, m_bad);
        chk("queue_drained", sel ? qb.size() : qa.size(), 0);
    endtask

    initial begin
        int w;
        #2 reset = 1'b1;
        #1;
        chk("rst_outputs", {we_a, addr_a, wd_a, busy_a, done_a, bad_a, ovf_a, ww_a, ifa.in_ready}, '0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("ready_idle", ifa.in_ready, 1'b0);

        // Session 1: directed addi / lw / j.
        start_sess(0);
        fields(0, 8, 0, 0, 0, 5, 0);     send(4, 32'h20080005, 0, w);
        fields(8, 9, 0, 0, 0, 4, 0);     send(1, 32'h8D090004, 0, w);
        fields(0, 0, 0, 0, 0, 0, 'h10);  send(5, 32'h08000010, 1, w);
        wait_done(1);
        end_checks();

        // Session 2: R-type, beq, illegal op, ignored start, then a random burst.
        start_sess(0);
        fields(9, 10, 11, 0, 'h20, 0, 0); send(0, 32'h012A5820, 0, w);
        fields(8, 9, 0, 0, 0, 'hFFFF, 0); send(3, 32'h1109FFFF, 0, w);
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        chk("busy_ignores_start", busy_a, 1'b1);
        fields($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        send(7, 32'h00000000, 0, w);
        chk("bad_op_sticky", bad_a, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rand_beat(i == 5, 7, w);
            chk("burst_no_stall", w, 0);
        end
        wait_done(1);
        end_checks();
        chk("bad_op_held_idle", bad_a, 1'b1);

        // Session 3: start clears flags; single-beat latency.
        start_sess(0);
        chk("bad_op_cleared", bad_a, 1'b0);
        fields($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        w = $urandom_range(0, 5);
        op = 3'(w); last = 1'b1; valid = 1'b1;
        chk("lat_ready", ifa.in_ready, 1'b1);
        @(posedge clk);
        push_model(w, ref_enc(w));
        #1 valid = 1'b0; last = 1'b0;
        @(negedge clk); chk("lat_we_n", we_a, 1'b0);
        @(negedge clk); chk("lat_we_n1", we_a, 1'b1);
        @(negedge clk); chk("lat_we_n2", we_a, 1'b0); chk("lat_done", done_a, 1'b1);
        @(negedge clk); chk("lat_done_low", done_a, 1'b0);
        @(posedge clk); #1;
        end_checks();

        // Reset in the middle of a session.
        start_sess(0);
        rand_beat(0, 7, w);
        rand_beat(0, 7, w);
        reset = 1'b1;
        qa.delete();
        #1;
        chk("midrst_we", we_a, 1'b0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_ready", ifa.in_ready, 1'b0);
        chk("midrst_ww", ww_a, 9'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start_sess(0);
        rand_beat(0, 5, w);
        rand_beat(1, 5, w);
        wait_done(1);
        end_checks();

        // Overflow at the top of the address space on the BASE=254 instance.
        start_sess(1);
        for (int i = 0; i < 4; i++) rand_beat(i == 3, 5, w);
        wait_done(0);
        end_checks();
        chk("ovf_flag_b", ovf_b, 1'b1);
        chk("ovf_ww_b", ww_b, 9'd2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader for the single-cycle MIPS core. It accepts instruction fields over a valid/ready stream, encodes each one into a 32-bit MIPS word using the same opcode map the main decoder consumes (R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010), buffers the words in a 4-entry FIFO, and writes them sequentially into instruction memory. It sits between the test/boot front end and the instruction-memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- BASE, 0, first word address written after `start`
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE)
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts fields this cycle
- in_last  in  1  qualifies the final instruction of the session (sampled with in_valid & in_ready)
- op_sel  in  3  0=R-type, 1=lw, 2=sw, 3=beq, 4=addi, 5=j, 6/7=illegal
- rs, rt, rd, shamt  in  5 each  register/shift fields
- funct  in  6  R-type function field
- imm  in  16  immediate/offset for lw, sw, beq, addi
- target  in  26  jump target for j
- im_we  out  1  instruction-memory write strobe, one cycle per word
- im_addr  out  ADDR_W  word address of the write
- im_wdata  out  32  encoded instruction
- busy  out  1  high in LOAD or DRAIN
- done  out  1  one-cycle pulse at session end
- bad_op  out  1  sticky: an illegal op_sel was accepted this session
- overflow  out  1  sticky: words were dropped past the top address
- words_written  out  ADDR_W+1  words committed this session

## Operation
- Encodings: R = {000000,rs,rt,rd,shamt,funct}; lw = {100011,rs,rt,imm}; sw = {101011,rs,rt,imm}; beq = {000100,rs,rt,imm}; addi = {001000,rs,rt,imm}; j = {000010,target}. Unused fields are ignored.
- Illegal op_sel (6, 7): encoded as 32'h00000000 (nop), written normally, and sets bad_op.
- FSM has four states:
  - IDLE: on `start`, set addr=BASE, clear words_written/bad_op/overflow, go to LOAD.
  - LOAD: accepts fields. An accepted beat with in_last goes to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- in_ready = (state==LOAD) && fifo_count<4. A FIFO pop in the same cycle does not free a slot (no bypass).
- Writer: whenever the FIFO is non-empty, pop the head and register im_we=1, im_addr=addr, im_wdata=word. Then increment addr and words_written.
- Overflow:
  - The word at address 2^ADDR_W-1 is written, and overflow is then set.
  - Later words are still accepted and popped but produce no im_we and do not count.
  - addr never wraps.
- start outside IDLE is ignored. Sticky flags hold through IDLE until the next start.

## Timing
- Reset values:
  - in_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - busy=0, done=0, bad_op=0, overflow=0, words_written=0.
  - FIFO empty, state IDLE.
- start at edge k: LOAD from cycle k+1, so in_ready can be high in cycle k+1.
- Fields accepted at edge n appear as im_we=1 with the word in the cycle after edge n+1. Latency is 2 cycles.
- Sustained throughput is 1 word/cycle.
- done rises the cycle after the final im_we cycle (empty FIFO observed at DRAIN).
- in_last accepted at edge n with an empty FIFO: final im_we in cycle n+1→n+2, done one cycle later.
- Reset asserted mid-session: all outputs drop asynchronously, FIFO contents are discarded, and no further im_we occurs.

## Test plan
- Reset, start, 3 beats (addi rs=0 rt=8 imm=5; lw rs=8 rt=9 imm=4; j target=0x10, last) → im_we at addr 0,1,2 with 0x20080005, 0x8D090004, 0x08000010. Then done one pulse, words_written=3.
- R-type rs=9 rt=10 rd=11 shamt=0 funct=0x20 and beq rs=8 rt=9 imm=0xFFFF → 0x012A5820 and 0x1109FFFF.
- op_sel=7 mid-stream → 0x00000000 written at its slot, bad_op=1. The next start clears bad_op.
- Hold im writes back by feeding 6 back-to-back beats → in_ready never high with fifo_count=4. All 6 words appear in order at consecutive addresses with no loss or duplication.
- BASE=254, ADDR_W=8, 4 beats → writes at 254 and 255, overflow=1, words_written=2, done still pulses.
- Assert reset two cycles after start with 2 beats in flight → im_we=0 immediately, state IDLE. The next session starts at BASE with clean flags.
